// File: rtl/act_index_reader.sv
// Activation-index RAM reader: fetches a run of packed index words and streams their lanes out.
// Build option ACT_IDX_EOL_EN: an all-ones lane acts as an end-of-list sentinel and ends the job.
module act_index_reader #(
  parameter int DWIDTH = 56,
  parameter int AWIDTH = 7,
  parameter int IWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  input  logic [DWIDTH-1:0] ram_q,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic [IWIDTH-1:0] idx_data,
  output logic              idx_last
);

  localparam int LANES = DWIDTH / IWIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0]   LAST_LANE = LW'(LANES - 1);
  localparam logic [AWIDTH:0] ONE_WORD  = (AWIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] r_cur_addr;
  logic [AWIDTH:0]   r_words_left;
  logic [DWIDTH-1:0] r_word;
  logic [LW-1:0]     r_lane;

  logic [IWIDTH-1:0] w_lane_data;
  logic              w_hs;
  logic              w_word_end;
  logic              w_eol;
  logic              w_final;

  always_comb begin
    w_lane_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (r_lane == LW'(i)) begin
        w_lane_data = r_word[i*IWIDTH +: IWIDTH];
      end
    end
  end

`ifdef ACT_IDX_EOL_EN
  assign w_eol = (w_lane_data == '1);
`else
  assign w_eol = 1'b0;
`endif

  assign w_hs       = (r_state == S_EMIT) && idx_ready;
  assign w_word_end = (r_lane == LAST_LANE);
  assign w_final    = (w_word_end && (r_words_left == ONE_WORD)) || w_eol;

  assign ram_we    = 1'b0;
  assign ram_addr  = r_cur_addr;
  assign idx_data  = w_lane_data;
  assign idx_last  = (r_state == S_EMIT) && w_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    ram_ce      = 1'b0;
    idx_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = (num_words == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        ram_ce      = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        idx_valid = 1'b1;
        if (w_hs) begin
          if (w_final) begin
            w_state_nxt = S_DONE;
          end else if (w_word_end) begin
            w_state_nxt = S_READ;
          end
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // RAM data lands one cycle after READ, so the word is captured in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr   <= '0;
      r_words_left <= '0;
      r_word       <= '0;
      r_lane       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (num_words != '0)) begin
            r_cur_addr   <= base_addr;
            r_words_left <= num_words;
          end
        end
        S_WAIT: begin
          r_word <= ram_q;
          r_lane <= '0;
        end
        S_EMIT: begin
          if (w_hs && !w_final) begin
            if (w_word_end) begin
              r_cur_addr   <= r_cur_addr + AWIDTH'(1);
              r_words_left <= r_words_left - ONE_WORD;
            end else begin
              r_lane <= r_lane + LW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
